// File: rtl/bar_redraw_scheduler.sv
// Incremental bar-graph redraw sequencer for the 160x120 vga_adapter pixel port.
// Optional feature macro: BAR_SCHED_OVERRUN_EN adds overrun / overrun_cnt outputs for dropped frame ticks.
module bar_redraw_scheduler #(
    parameter int NUM_BARS  = 8,
    parameter int AMP_W     = 3,
    parameter int BAR_W     = 16,
    parameter int BAR_PITCH = 20,
    parameter int X_ORIGIN  = 2,
    parameter int UNIT_H    = 15,
    parameter int SCR_H     = 120
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_tick,
    input  logic [NUM_BARS*AMP_W-1:0] amp_bus,
    input  logic                      pix_ready,
    output logic [7:0]                x,
    output logic [6:0]                y,
    output logic [2:0]                colour,
    output logic                      plot,
    output logic                      busy,
    output logic                      frame_done
`ifdef BAR_SCHED_OVERRUN_EN
    ,
    output logic                      overrun,
    output logic [7:0]                overrun_cnt
`endif
);

    localparam int IDX_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam int COL_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [IDX_W-1:0] LAST_BAR = IDX_W'(NUM_BARS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(BAR_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, DRAW, NEXT, DONE} state_t;

    state_t state;
    state_t state_next;

    logic [NUM_BARS*AMP_W-1:0] amp_shadow;
    logic [IDX_W-1:0]          bar_idx;
    logic [6:0]                old_h [NUM_BARS];
    logic [6:0]                nh_r;
    logic [6:0]                row;
    logic [6:0]                row_last;
    logic [COL_W-1:0]          col;
    logic [2:0]                draw_colour;

    logic [AMP_W-1:0]          cur_amp;
    logic [6:0]                nh;
    logic [6:0]                oh;
    logic [1:0]                colour_k;
    logic [2:0]                bar_colour;
    logic                      xfer;
    logic                      last_pixel;

    // Per-bar target height, previous height and palette entry for the bar being set up.
    always_comb begin
        cur_amp    = amp_shadow[bar_idx*AMP_W +: AMP_W];
        nh         = 7'(UNIT_H) * (7'(cur_amp) + 7'd1);
        oh         = old_h[bar_idx];
        colour_k   = 2'((32'(bar_idx) * 4) / NUM_BARS);
        case (colour_k)
            2'd0:    bar_colour = 3'b001;
            2'd1:    bar_colour = 3'b010;
            2'd2:    bar_colour = 3'b110;
            default: bar_colour = 3'b100;
        endcase
        xfer       = (state == DRAW) && pix_ready;
        last_pixel = (col == LAST_COL) && (row == row_last);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_tick) state_next = SETUP;
            SETUP:   state_next = (nh == oh) ? NEXT : DRAW;
            DRAW:    if (xfer && last_pixel) state_next = NEXT;
            NEXT:    state_next = (bar_idx == LAST_BAR) ? DONE : SETUP;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pixel outputs are forced to zero outside DRAW so the port idles at x=0, y=0, colour=0.
    always_comb begin
        plot       = (state == DRAW);
        busy       = (state == SETUP) || (state == DRAW) || (state == NEXT);
        frame_done = (state == DONE);
        x          = '0;
        y          = '0;
        colour     = '0;
        if (state == DRAW) begin
            x      = 8'(X_ORIGIN) + 8'(BAR_PITCH) * 8'(bar_idx) + 8'(col);
            y      = row;
            colour = draw_colour;
        end
    end

    // Row/column walk: column is the inner loop, so row only steps after the last column transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            amp_shadow  <= '0;
            bar_idx     <= '0;
            nh_r        <= '0;
            row         <= '0;
            row_last    <= '0;
            col         <= '0;
            draw_colour <= '0;
            for (int i = 0; i < NUM_BARS; i++) begin
                old_h[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        amp_shadow <= amp_bus;
                        bar_idx    <= '0;
                    end
                end
                SETUP: begin
                    nh_r <= nh;
                    col  <= '0;
                    if (nh > oh) begin
                        row         <= 7'(SCR_H) - nh;
                        row_last    <= 7'(SCR_H) - oh - 7'd1;
                        draw_colour <= bar_colour;
                    end else begin
                        row         <= 7'(SCR_H) - oh;
                        row_last    <= 7'(SCR_H) - nh - 7'd1;
                        draw_colour <= 3'b000;
                    end
                end
                DRAW: begin
                    if (xfer) begin
                        if (col == LAST_COL) begin
                            col <= '0;
                            if (row == row_last) begin
                                old_h[bar_idx] <= nh_r;
                            end else begin
                                row <= row + 7'd1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                NEXT: begin
                    if (bar_idx != LAST_BAR) begin
                        bar_idx <= bar_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BAR_SCHED_OVERRUN_EN
    // A tick that lands while a frame is in flight is dropped; record it here.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun     <= 1'b0;
            overrun_cnt <= 8'd0;
        end else if (frame_tick && busy) begin
            overrun <= 1'b1;
            if (overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bar_redraw_scheduler.sv
// Scoreboard bench for bar_redraw_scheduler: a behavioural model queues the expected pixel stream
// when each frame is launched, and the monitor pops and compares every transferred pixel.
`timescale 1ns/1ps
module tb_bar_redraw_scheduler;

    localparam int NUM_BARS = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic [23:0] amp_bus;
    logic        pix_ready;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        frame_done;
`ifdef BAR_SCHED_OVERRUN_EN
    logic        overrun;
    logic [7:0]  overrun_cnt;
`endif

    int          checks = 0;
    int          passes = 0;
    logic [17:0] exp_q[$];
    int          model_h [NUM_BARS];
    int          bar_colour_tbl [NUM_BARS] = '{1, 1, 2, 2, 6, 6, 4, 4};
    int          xfer_cnt = 0;
    int          stall_cycles = 0;
    int          ready_mode = 0;
    int          stall_at = 0;
    int          stall_left = 0;
    logic        hold_pending = 1'b0;
    logic [18:0] held = '0;

    bar_redraw_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .amp_bus    (amp_bus),
        .pix_ready  (pix_ready),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef BAR_SCHED_OVERRUN_EN
        ,
        .overrun    (overrun),
        .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // pix_ready: 0 = always high, 1 = random throttle, 2 = one 5-cycle stall once stall_at transfers are seen
    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                pix_ready = 1'b0;
                stall_left--;
            end else if (ready_mode == 2 && xfer_cnt >= stall_at) begin
                pix_ready  = 1'b0;
                stall_left = 4;
                ready_mode = 0;
            end else if (ready_mode == 1) begin
                pix_ready = ($urandom_range(3) != 0);
            end else begin
                pix_ready = 1'b1;
            end
        end
    end

    initial begin
        logic [17:0] pix;
        logic [17:0] exp_pix;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    checkOutput("stall_hold", {13'd0, plot, x, y, colour}, {13'd0, held});
                end
                hold_pending = plot && !pix_ready;
                held         = {plot, x, y, colour};
                if (plot && !pix_ready) stall_cycles++;
                if (plot && pix_ready) begin
                    xfer_cnt++;
                    pix = {x, y, colour};
                    if (exp_q.size() == 0) begin
                        checkOutput("extra_pixel", {14'd0, pix}, 32'hFFFF_FFFF);
                    end else begin
                        exp_pix = exp_q.pop_front();
                        checkOutput("pixel", {14'd0, pix}, {14'd0, exp_pix});
                    end
                end
            end
        end
    end

    // Queues the model's pixel stream for a new amplitude set, pulses frame_tick, checks tick-to-plot latency.
    task automatic applyStimulus(input logic [23:0] amps, input string tag);
        int   nh;
        int   oh;
        int   lo;
        int   hi;
        int   col_v;
        logic first_bar_draws;
        first_bar_draws = 1'b0;
        for (int i = 0; i < NUM_BARS; i++) begin
            nh = 15 * (int'(amps[i*3 +: 3]) + 1);
            oh = model_h[i];
            if (nh > oh) begin
                lo    = 120 - nh;
                hi    = 119 - oh;
                col_v = bar_colour_tbl[i];
            end else begin
                lo    = 120 - oh;
                hi    = 119 - nh;
                col_v = 0;
            end
            if (nh != oh) begin
                if (i == 0) first_bar_draws = 1'b1;
                for (int r = lo; r <= hi; r++) begin
                    for (int c = 0; c < 16; c++) begin
                        exp_q.push_back({8'(2 + 20 * i + c), 7'(r), 3'(col_v)});
                    end
                end
            end
            model_h[i] = nh;
        end
        amp_bus    = amps;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_busy_after_tick"}, {30'd0, busy, plot}, {30'd0, 1'b1, 1'b0});
        @(negedge clk);
        checkOutput({tag, "_first_plot_latency"}, plot, first_bar_draws);
    endtask

    task automatic waitFrameDone(input string tag, input int exp_pixels, input int max_cycles,
                                 input int start_xfer, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < max_cycles) begin
            @(negedge clk);
            cycles++;
            if (frame_done) seen = 1'b1;
        end
        checkOutput({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            checkOutput({tag, "_busy_in_done"}, busy, 0);
            @(negedge clk);
            checkOutput({tag, "_done_pulse_width"}, frame_done, 0);
            checkOutput({tag, "_pixel_count"}, xfer_cnt - start_xfer, exp_pixels);
            checkOutput({tag, "_queue_drained"}, exp_q.size(), 0);
        end
    endtask

    initial begin
        int start;
        int cycles;
        int stall_start;
        int guard;
        reset      = 1'b1;
        frame_tick = 1'b0;
        amp_bus    = '0;
        for (int i = 0; i < NUM_BARS; i++) model_h[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_plot_busy_done", {29'd0, plot, busy, frame_done}, 0);
        checkOutput("reset_xy_colour", {14'd0, x, y, colour}, 0);
`ifdef BAR_SCHED_OVERRUN_EN
        checkOutput("reset_overrun", {23'd0, overrun_cnt, overrun}, 0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] frame from black, all amplitudes 0");
        start = xfer_cnt;
        applyStimulus(24'h000000, "all_zero");
        waitFrameDone("all_zero", 1920, 1920 + 64, start, cycles);

        $display("[TB] repeat frame, nothing changes");
        start = xfer_cnt;
        applyStimulus(24'h000000, "no_change");
        waitFrameDone("no_change", 0, 40, start, cycles);
        checkOutput("no_change_done_latency", (cycles + 1 <= 2 + 2 * NUM_BARS), 1);

        $display("[TB] bar 3 grows to amp 3, then shrinks to amp 1");
        start = xfer_cnt;
        applyStimulus(24'(3 << 9), "bar3_grow");
        waitFrameDone("bar3_grow", 720, 720 + 64, start, cycles);
        start = xfer_cnt;
        applyStimulus(24'(1 << 9), "bar3_shrink");
        waitFrameDone("bar3_shrink", 480, 480 + 64, start, cycles);

        $display("[TB] bar 0 grows to full height with a stall mid-row");
        start       = xfer_cnt;
        stall_start = stall_cycles;
        stall_at    = xfer_cnt + 100;
        ready_mode  = 2;
        applyStimulus(24'((1 << 9) | 7), "bar0_full");
        waitFrameDone("bar0_full", 1680, 1680 + 64, start, cycles);
        checkOutput("bar0_stall_cycles", stall_cycles - stall_start, 5);

        $display("[TB] all bars to max under random throttle, tick and amp change while busy");
        ready_mode = 1;
        start      = xfer_cnt;
        applyStimulus(24'hFFFFFF, "all_max");
        repeat (40) @(posedge clk);
        #1;
        checkOutput("busy_before_extra_tick", busy, 1);
        frame_tick = 1'b1;
        amp_bus    = 24'h000000;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        waitFrameDone("all_max", 11520, 11520 * 4 + 64, start, cycles);
`ifdef BAR_SCHED_OVERRUN_EN
        checkOutput("overrun_flag", overrun, 1);
        checkOutput("overrun_cnt", overrun_cnt, 1);
`endif
        ready_mode = 0;

        $display("[TB] reset in the middle of a shrink frame, then redraw from black");
        start = xfer_cnt;
        applyStimulus(24'h000000, "abort");
        guard = 0;
        while ((xfer_cnt - start) < 200 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("abort_reached_draw", guard < 1000, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_plot_busy", {30'd0, plot, busy}, 0);
`ifdef BAR_SCHED_OVERRUN_EN
        checkOutput("abort_overrun_cleared", {23'd0, overrun_cnt, overrun}, 0);
`endif
        exp_q.delete();
        for (int i = 0; i < NUM_BARS; i++) model_h[i] = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        start = xfer_cnt;
        applyStimulus(24'h000000, "after_abort");
        waitFrameDone("after_abort", 1920, 1920 + 64, start, cycles);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
